// File: rtl/log2_hist_pkg.sv
// Shared constants and state type for the log2-code histogram accumulator.
package log2_hist_pkg;

    localparam int unsigned NBINS = 12;
    localparam int unsigned BIN_W = 4;

    localparam logic [BIN_W-1:0] OOR_CODE = 4'd12;
    localparam logic [BIN_W-1:0] LAST_BIN = 4'd11;

    typedef enum logic {
        ST_ACC,
        ST_DUMP
    } state_t;

endpackage

// File: rtl/log2_hist_cnt.sv
// Single histogram bin counter with increment/clear and reach-maximum pulse.
// Saturating when HIST_SAT_EN is defined, wrapping otherwise.
module log2_hist_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

`ifdef HIST_SAT_EN
    logic at_max;

    assign at_max = (count == '1);
    // Pulses only on the increment that lands exactly on the maximum.
    assign sat    = inc && !clr && (count == ~CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end
`else
    assign sat = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/log2_hist.sv
// Log2-code histogram: counts codes 0..11 into bins, streams counts out on request.
// Optional saturating counters via HIST_SAT_EN.
module log2_hist
    import log2_hist_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       DatIn,
    input  logic             Clear,
    input  logic             DumpReq,
    input  logic             ClrOnDump,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [3:0]       OutBin,
    output logic [CNT_W-1:0] OutCount,
    output logic             Done,
    output logic             OorErr,
    output logic             LostErr,
    output logic             SatErr
);

    state_t           state, state_nxt;
    logic [BIN_W-1:0] ptr, ptr_nxt;
    logic             cod, cod_nxt;
    logic             done_nxt;
    logic             oor_nxt, lost_nxt, flags_clr;

    logic [NBINS-1:0] inc, clr, sat_hit;
    logic [CNT_W-1:0] cnt [NBINS];

    for (genvar g = 0; g < NBINS; g++) begin : g_bin
        log2_hist_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (Clk),
            .rst_n(Rst_n),
            .inc  (inc[g]),
            .clr  (clr[g]),
            .count(cnt[g]),
            .sat  (sat_hit[g])
        );
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= ST_ACC;
            ptr     <= '0;
            cod     <= 1'b0;
            Done    <= 1'b0;
            OorErr  <= 1'b0;
            LostErr <= 1'b0;
            SatErr  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cod     <= cod_nxt;
            Done    <= done_nxt;
            OorErr  <= oor_nxt;
            LostErr <= lost_nxt;
            SatErr  <= flags_clr ? 1'b0 : (SatErr | (|sat_hit));
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cod_nxt   = cod;
        done_nxt  = 1'b0;
        oor_nxt   = OorErr;
        lost_nxt  = LostErr;
        flags_clr = 1'b0;
        inc       = '0;
        clr       = '0;

        unique case (state)
            ST_ACC: begin
                if (Clear) begin
                    clr       = '1;
                    flags_clr = 1'b1;
                    oor_nxt   = 1'b0;
                    lost_nxt  = 1'b0;
                end else begin
                    if (InValid) begin
                        if (DatIn >= OOR_CODE) begin
                            oor_nxt = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < NBINS; i++) begin
                                inc[i] = (DatIn == BIN_W'(i));
                            end
                        end
                    end
                    // The same-cycle sample is counted before the readout begins.
                    if (DumpReq) begin
                        state_nxt = ST_DUMP;
                        ptr_nxt   = '0;
                        cod_nxt   = ClrOnDump;
                    end
                end
            end
            ST_DUMP: begin
                if (InValid) begin
                    lost_nxt = 1'b1;
                end
                if (OutReady) begin
                    for (int unsigned i = 0; i < NBINS; i++) begin
                        clr[i] = cod && (ptr == BIN_W'(i));
                    end
                    if (ptr == LAST_BIN) begin
                        state_nxt = ST_ACC;
                        ptr_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        ptr_nxt = ptr + BIN_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_ACC;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Outputs depend only on registered state, never on OutReady.
    always_comb begin
        InReady  = (state == ST_ACC);
        OutValid = (state == ST_DUMP);
        OutBin   = ptr;
        OutCount = '0;
        if (state == ST_DUMP) begin
            for (int unsigned i = 0; i < NBINS; i++) begin
                if (ptr == BIN_W'(i)) begin
                    OutCount = cnt[i];
                end
            end
        end
    end

endmodule
